// File: rtl/iomem_gpio_ctrl.sv
// iomem_gpio_ctrl: parametrised GPIO peripheral on the PicoSoC iomem bus.
// Latency: one cycle from address hit to the iomem_ready pulse; gpio_in rise to irq is 5 cycles with DEB_DIV=0.
// Backpressure: none; every hit completes on the next edge and ready drops for one cycle before the next access.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   iomem_valid/ready    request / one-cycle completion pulse
//   iomem_wstrb          byte write strobes (0 = read)
//   iomem_addr/wdata     byte address (addr[31:24] decoded against BASE_ADDR) and write data
//   iomem_rdata          read data, valid while iomem_ready=1
//   gpio_in              asynchronous inputs (synchronised, optionally debounced)
//   gpio_out             registered outputs
//   irq                  registered level interrupt, |(IRQ_STAT & IRQ_EN)
//
// Register map (offset = addr[7:0]): 0x00 OUT rw, 0x04 IN ro, 0x08 IRQ_EN rw, 0x0C IRQ_STAT rw1c.
module iomem_gpio_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'h03,
  parameter int         N_OUT     = 16,
  parameter int         N_IN      = 16,
  parameter int         DEB_DIV   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out,
  output logic              irq
);

  // The prescaler needs at least one bit even when it never counts.
  localparam int            PW      = (DEB_DIV > 0) ? $clog2(DEB_DIV + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DEB_DIV);

  localparam logic [7:0] OFF_OUT  = 8'h00;
  localparam logic [7:0] OFF_IN   = 8'h04;
  localparam logic [7:0] OFF_EN   = 8'h08;
  localparam logic [7:0] OFF_STAT = 8'h0C;

  logic              ready_q,      ready_d;
  logic [31:0]       rdata_q,      rdata_d;
  logic [N_OUT-1:0]  out_q,        out_d;
  logic [N_IN-1:0]   en_q,         en_d;
  logic [N_IN-1:0]   stat_q,       stat_d;
  logic              irq_q,        irq_d;
  logic [N_IN-1:0]   sync1_q,      sync2_q;
  logic [N_IN-1:0]   stable_q,     stable_d;
  logic [N_IN-1:0]   stable_dly_q;
  logic [PW-1:0]     pre_q,        pre_d;

  logic              hit;
  logic              wr;
  logic              sample;
  logic [7:0]        off;
  logic [31:0]       strb_mask;
  logic [31:0]       out_ext, in_ext, en_ext, stat_ext;
  logic [31:0]       rd_mux;
  logic [31:0]       out_wr, en_wr, stat_clr;
  logic [N_IN-1:0]   clr;
  logic [N_IN-1:0]   rise;
  logic              unused_bits;

  // Address bits 23:8 are not decoded; high bits of the 32-bit merge results
  // beyond the configured widths are deliberately dropped.
  assign unused_bits = ^{iomem_addr[23:8], out_wr, en_wr, stat_clr};

  always_comb begin
    // A request already being acknowledged is not a new hit, which forces
    // a one-cycle gap between back-to-back accesses.
    hit       = iomem_valid & ~ready_q & (iomem_addr[31:24] == BASE_ADDR);
    wr        = hit & (|iomem_wstrb);
    off       = iomem_addr[7:0];
    strb_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                 {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

    // Zero-extend registers to the bus width so unimplemented bits read 0.
    out_ext  = '0;
    in_ext   = '0;
    en_ext   = '0;
    stat_ext = '0;
    out_ext[N_OUT-1:0] = out_q;
    in_ext[N_IN-1:0]   = stable_q;
    en_ext[N_IN-1:0]   = en_q;
    stat_ext[N_IN-1:0] = stat_q;

    rd_mux = '0;
    case (off)
      OFF_OUT:  rd_mux = out_ext;
      OFF_IN:   rd_mux = in_ext;
      OFF_EN:   rd_mux = en_ext;
      OFF_STAT: rd_mux = stat_ext;
      default:  rd_mux = '0;
    endcase

    out_wr   = (out_ext & ~strb_mask) | (iomem_wdata & strb_mask);
    en_wr    = (en_ext  & ~strb_mask) | (iomem_wdata & strb_mask);
    stat_clr = iomem_wdata & strb_mask;

    ready_d = hit;
    // rdata carries the pre-write value on a write access.
    rdata_d = hit ? rd_mux : 32'h0;
    out_d   = out_q;
    en_d    = en_q;
    if (wr && (off == OFF_OUT)) out_d = out_wr[N_OUT-1:0];
    if (wr && (off == OFF_EN))  en_d  = en_wr[N_IN-1:0];

    clr = '0;
    if (wr && (off == OFF_STAT)) clr = stat_clr[N_IN-1:0];

    // Rising edge seen one cycle after the debounced value updates; OR-ing
    // it in after the clear makes a simultaneous edge win over W1C.
    rise   = stable_q & ~stable_dly_q;
    stat_d = (stat_q & ~clr) | rise;
    irq_d  = |(stat_q & en_q);

    sample   = (pre_q == PRE_MAX);
    pre_d    = sample ? '0 : pre_q + PW'(1);
    stable_d = sample ? sync2_q : stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      out_q        <= '0;
      en_q         <= '0;
      stat_q       <= '0;
      irq_q        <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pre_q        <= '0;
    end else begin
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      out_q        <= out_d;
      en_q         <= en_d;
      stat_q       <= stat_d;
      irq_q        <= irq_d;
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pre_q        <= pre_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio_ctrl.sv
// Bench for iomem_gpio_ctrl: two instances (DEB_DIV=0 and DEB_DIV=3) share the bus;
// expected read data is queued per instance at issue time and checked by a monitor on each ready pulse.
module tb_iomem_gpio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [15:0] gpio_in0, gpio_in3;
  logic        ready0, ready3;
  logic [31:0] rdata0, rdata3;
  logic [15:0] gpio_out0, gpio_out3;
  logic        irq0, irq3;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  iomem_gpio_ctrl #(.BASE_ADDR(8'h03), .N_OUT(16), .N_IN(16), .DEB_DIV(0)) dut0 (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(ready0),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(rdata0), .gpio_in(gpio_in0), .gpio_out(gpio_out0), .irq(irq0)
  );

  iomem_gpio_ctrl #(.BASE_ADDR(8'h03), .N_OUT(16), .N_IN(16), .DEB_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(ready3),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(rdata3), .gpio_in(gpio_in3), .gpio_out(gpio_out3), .irq(irq3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ready0 === 1'b1) begin
      if (q0.size() == 0) check("dut0 unexpected ready", 32'h1, 32'h0);
      else check("dut0 rdata", rdata0, q0.pop_front());
    end
    if (ready3 === 1'b1) begin
      if (q3.size() == 0) check("dut3 unexpected ready", 32'h1, 32'h0);
      else check("dut3 rdata", rdata3, q3.pop_front());
    end
  end

  // Called at 1ns after a rising edge; returns at 1ns after the edge where ready is seen.
  task automatic access(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                        input logic [31:0] e0, input logic [31:0] e3);
    bit got = 0;
    q0.push_back(e0);
    q3.push_back(e3);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = ws;
    iomem_wdata = wd;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready0 === 1'b1) begin
        got = 1;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    if (!got) begin
      check("access timeout", 32'h0, 32'h1);
      void'(q0.pop_back());
      void'(q3.pop_back());
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nready;
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    gpio_in0    = 16'h0;
    gpio_in3    = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset gpio_out", {16'h0, gpio_out0}, 32'h0);
    check("reset irq",      {31'h0, irq0},      32'h0);
    check("reset ready",    {31'h0, ready0},    32'h0);

    // Byte-lane writes to OUT; upper lanes beyond N_OUT are not stored.
    access(32'h0300_0000, 4'b0011, 32'h0000_A5C3, 32'h0, 32'h0);
    check("out after A5C3", {16'h0, gpio_out0}, 32'h0000_A5C3);
    access(32'h0300_0000, 4'b0010, 32'h0000_FF00, 32'h0000_A5C3, 32'h0000_A5C3);
    check("out after lane1", {16'h0, gpio_out0}, 32'h0000_FFC3);
    access(32'h0300_0000, 4'b0000, 32'h0, 32'h0000_FFC3, 32'h0000_FFC3);
    access(32'h0300_0000, 4'b1100, 32'hFFFF_0000, 32'h0000_FFC3, 32'h0000_FFC3);
    access(32'h0300_0000, 4'b0000, 32'h0, 32'h0000_FFC3, 32'h0000_FFC3);

    // Input sync and edge capture, interrupt disabled.
    gpio_in0 = 16'h0001;
    cycles(6);
    access(32'h0300_0004, 4'b0000, 32'h0, 32'h1, 32'h0);
    access(32'h0300_000C, 4'b0000, 32'h0, 32'h1, 32'h0);
    check("irq masked", {31'h0, irq0}, 32'h0);

    // Enable: irq follows one cycle after IRQ_EN commits.
    access(32'h0300_0008, 4'b0001, 32'h1, 32'h0, 32'h0);
    check("irq before en reg", {31'h0, irq0}, 32'h0);
    cycles(1);
    check("irq enabled", {31'h0, irq0}, 32'h1);

    // W1C clears status; irq drops one cycle later.
    access(32'h0300_000C, 4'b0001, 32'h1, 32'h1, 32'h0);
    check("irq right after w1c", {31'h0, irq0}, 32'h1);
    cycles(1);
    check("irq after w1c", {31'h0, irq0}, 32'h0);
    access(32'h0300_000C, 4'b0000, 32'h0, 32'h0, 32'h0);

    // New rise commits on the same edge as a W1C: set wins.
    gpio_in0 = 16'h0000;
    cycles(6);
    gpio_in0 = 16'h0001;
    cycles(3);
    access(32'h0300_000C, 4'b0001, 32'h1, 32'h0, 32'h0);
    check("irq at collision edge", {31'h0, irq0}, 32'h0);
    cycles(1);
    check("irq after collision", {31'h0, irq0}, 32'h1);
    access(32'h0300_000C, 4'b0000, 32'h0, 32'h1, 32'h0);
    check("irq held", {31'h0, irq0}, 32'h1);

    // Foreign base address: never acknowledged, no state change.
    nready = 0;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    iomem_wstrb = 4'b1111;
    iomem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready0 === 1'b1 || ready3 === 1'b1) nready++;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    check("foreign addr ready count", nready, 32'h0);
    access(32'h0300_0000, 4'b0000, 32'h0, 32'h0000_FFC3, 32'h0000_FFC3);
    access(32'h0300_0008, 4'b0000, 32'h0, 32'h1, 32'h1);
    access(32'h03AB_CD00, 4'b0000, 32'h0, 32'h0000_FFC3, 32'h0000_FFC3);
    access(32'h0300_0020, 4'b0000, 32'h0, 32'h0, 32'h0);

    // Reset on the edge that would complete a full-width write.
    gpio_in0    = 16'h0000;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000;
    iomem_wstrb = 4'b1111;
    iomem_wdata = 32'h1234_5678;
    reset       = 1'b1;
    @(posedge clk); #1;
    reset       = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    check("abort ready",    {31'h0, ready0},    32'h0);
    check("abort gpio_out", {16'h0, gpio_out0}, 32'h0);
    check("abort irq",      {31'h0, irq0},      32'h0);
    cycles(1);
    check("abort ready late", {31'h0, ready0}, 32'h0);
    access(32'h0300_0000, 4'b0000, 32'h0, 32'h0, 32'h0);
    access(32'h0300_0008, 4'b0000, 32'h0, 32'h0, 32'h0);
    access(32'h0300_000C, 4'b0000, 32'h0, 32'h0, 32'h0);

    // DEB_DIV=3: samples land 4, 8, ... edges after reset. A 2-cycle pulse
    // raised after edge R+2 only reaches in_sync for edges R+5 and R+6.
    do_reset();
    cycles(2);
    gpio_in3 = 16'h0001;
    cycles(2);
    gpio_in3 = 16'h0000;
    cycles(10);
    access(32'h0300_0004, 4'b0000, 32'h0, 32'h0, 32'h0);
    access(32'h0300_000C, 4'b0000, 32'h0, 32'h0, 32'h0);
    gpio_in3 = 16'h0001;
    cycles(12);
    access(32'h0300_0004, 4'b0000, 32'h0, 32'h0, 32'h1);
    access(32'h0300_000C, 4'b0000, 32'h0, 32'h0, 32'h1);

    cycles(3);
    check("dut0 queue drained", q0.size(), 32'h0);
    check("dut3 queue drained", q3.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
